cluster_unpacker: RTL and testbench
===================================

# cluster_unpacker

Reconstructs the chamber S-bit map from the eight 14-bit cluster words produced by the cluster packer, one packet per transaction. Each cluster is `{cnt[2:0], adr[10:0]}`, where `adr` is the linear pad address `row*192 + key` and `cnt+1` is the number of adjacent pads hit. The block sits on the monitoring/loopback side of the trigger path. Its uses are checking the packer in-system and feeding emulated S-bits to downstream logic. It is not rate-matched to every bunch crossing.

## Interface
Parameters:
- `MXSBITS`, 64, S-bits per VFAT
- `MXKEYS`, 192, S-bits per eta partition
- `MXPADS`, 1536, S-bits per chamber
- `MXROWS`, 8, eta partitions
- `MXCLUSTERS`, 8, clusters per packet
- `MXCLSTBITS`, 14, bits per cluster word

Ports:
- `clock4x`  in  1  single clock for all logic
- `global_reset_n`  in  1  reset; asynchronous, active-low
- `cluster0`..`cluster7`  in  14 each  cluster words, priority order
- `in_valid`  in  1  cluster words valid
- `in_ready`  out  1  block accepts a packet this cycle
- `sbits`  out  1536  reconstructed map, VFAT order: bit `vfat*64+ch`
- `n_clusters`  out  4  valid clusters in the packet, 0..8
- `overlap_err`  out  1  a cluster hit a pad already set by an earlier cluster in the packet
- `order_err`  out  1  a valid cluster followed an invalid one in the packet
- `out_valid`  out  1  `sbits`, `n_clusters` and both error flags are valid
- `out_ready`  in  1  consumer accepts the result

## Operation
- **Validity.** A cluster is valid iff `adr < 1536`. Empty slots carry `0x7FE` or `0x7FF`, and `cnt` is ignored for them.
- **Address decode.**
  - `row = adr / 192`, `key = adr % 192`.
  - Pads `key .. key+cnt` are set, clipped at key 191. Clipping is silent and never crosses into the next row.
- **Pad to VFAT mapping.** `vfat = (key/64)*8 + row`, `ch = key % 64`. This is the inverse of the partition map `{vfat(16+r), vfat(8+r), vfat(r)}`.
- **States.**
  - IDLE: `in_ready=1`. On `in_valid`, latch the 8 words, clear the accumulator, counter and flags, set `idx=0`, and go to EXPAND.
  - EXPAND: process clusters `2*idx` and `2*idx+1` per cycle. For each, OR its mask into the accumulator, increment `n_clusters` if valid, and update the flags. After `idx=3`, go to HOLD.
  - HOLD: `out_valid=1`, outputs stable.
    - If `out_ready` and `in_valid` are both high, accept the new packet (`in_ready=1`) and go to EXPAND.
    - If `out_ready` is high and `in_valid` is low, go to IDLE.
- **Error flags.**
  - `overlap_err` is set if a mask ANDed with the accumulator is non-zero. For the pair in one cycle, this includes overlap between the two masks.
  - `order_err` is set if any earlier slot in the packet was invalid.
  - Both flags are per-packet, not sticky across packets.
- **Reset.** Asserted at any time, including mid-EXPAND: state goes to IDLE and every register clears immediately. The partial packet is discarded.

## Timing
- Cycle 0: `in_valid && in_ready` handshake.
- Cycles 1–4: EXPAND, pairs 0–3.
- Cycle 5: `out_valid=1`. Latency is fixed at 5 cycles regardless of content.
- Minimum packet period is 5 cycles (HOLD-to-EXPAND back-to-back accept).
- `in_ready` is combinational: `(state==IDLE) || (state==HOLD && out_ready)`. It is forced to 0 while `global_reset_n` is low.
- `in_ready=0` throughout EXPAND. Input words are don't-care outside the accept cycle.
- Reset values:
  - `sbits`: all 0
  - `n_clusters`: 0
  - `overlap_err`, `order_err`: 0
  - `out_valid`: 0
  - `in_ready`: 0 while reset is asserted, 1 in IDLE once reset is released
- Outputs are registered and held unchanged in HOLD under backpressure.

## Structure
- **Shared package `gem_cluster_pkg`.**
  - Constants: `MXSBITS`, `MXKEYS`, `MXPADS`, `MXROWS`, `MXCNTBITS` (3), `MXADRBITS` (11), `MXCLSTBITS`, `MXCLUSTERS`, `ADR_INVALID` (`0x7FE`).
  - Cluster typedef: `{cnt, adr}`.
  - Function `pad_to_vfat_bit(row, key)`.
- **Sub-module `cluster_expander`.**
  - Combinational: one cluster word in; 1536-bit VFAT-ordered mask and a `valid` bit out.
  - Instantiated twice. The top level holds the FSM, the 2-bit `idx`, the accumulator and the flags.

## Test plan
- **Single pad.** `cluster0 = {0, 0}`, slots 1–7 `0x7FF` -> cycle 5: `out_valid=1`, `sbits` only bit 0 set, `n_clusters=1`, both flags 0.
- **Width and row mapping.** `cluster0 = {3, 200}` (row 1, key 8) -> bits 72..75 set (vfat1, ch 8..11), `n_clusters=1`.
- **Clip at row end.** `cluster0 = {7, 191}` -> only bit 1087 set (vfat16, ch 63); row 1 untouched.
- **Overlap within a pair.** `cluster0 = {2, 10}`, `cluster1 = {0, 12}` -> bits 10..12 set, `n_clusters=2`, `overlap_err=1`.
- **Out of order.** `cluster0 = 0x7FF`, `cluster1 = {0, 5}`, `cluster2 = {1, 64}` -> bits 5, 512 and 513 set (vfat8, ch 0..1), `n_clusters=2`, `order_err=1`.
- **Backpressure and reset.**
  - Hold `out_ready=0` for 10 cycles -> `out_valid` and `sbits` stable, `in_ready=0`.
  - Then `out_ready=1` with `in_valid=1` -> new packet accepted the same cycle.
  - Pull `global_reset_n` low in cycle 2 of EXPAND -> all outputs 0 at once, state IDLE, no `out_valid` for that packet.

Source files
------------

// File: rtl/gem_cluster_pkg.sv
// rtl/gem_cluster_pkg.sv - shared GEM cluster constants, cluster word type and pad-to-VFAT mapping
package gem_cluster_pkg;

  localparam int MXSBITS    = 64;
  localparam int MXKEYS     = 192;
  localparam int MXPADS     = 1536;
  localparam int MXROWS     = 8;
  localparam int MXCNTBITS  = 3;
  localparam int MXADRBITS  = 11;
  localparam int MXCLSTBITS = 14;
  localparam int MXCLUSTERS = 8;

  localparam logic [MXADRBITS-1:0] ADR_INVALID = 11'h7FE;

  typedef struct packed {
    logic [MXCNTBITS-1:0] cnt;
    logic [MXADRBITS-1:0] adr;
  } cluster_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_HOLD
  } state_t;

  // key < 192, so key/64 is key[7:6] and (key/64)*8 + row packs as {key[7:6], row}.
  function automatic logic [MXADRBITS-1:0] pad_to_vfat_bit(input logic [2:0] row,
                                                           input logic [7:0] key);
    logic [4:0] vfat;
    vfat = {key[7:6], row};
    return {vfat, key[5:0]};
  endfunction

endpackage

// File: rtl/cluster_expander.sv
// rtl/cluster_expander.sv - one cluster word to a VFAT-ordered pad mask, clipped at the row end
module cluster_expander
  import gem_cluster_pkg::*;
(
  input  logic [MXCLSTBITS-1:0] cluster,
  output logic [MXPADS-1:0]     mask,
  output logic                  valid
);

  cluster_t   c;
  logic [2:0] row;
  logic [7:0] key;

  assign c = cluster_t'(cluster);

  always_comb begin
    mask  = '0;
    valid = c.adr < 11'(MXPADS);
    row   = 3'(c.adr / 11'(MXKEYS));
    key   = 8'(c.adr % 11'(MXKEYS));
    if (valid) begin
      for (int k = 0; k < 8; k++) begin
        if (k <= int'(c.cnt) && int'(key) + k < MXKEYS) begin
          mask[pad_to_vfat_bit(row, 8'(int'(key) + k))] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cluster_unpacker.sv
// rtl/cluster_unpacker.sv - rebuilds the chamber S-bit map from an 8-cluster packet, two clusters per cycle
module cluster_unpacker
  import gem_cluster_pkg::*;
(
  input  logic                  clock4x,
  input  logic                  global_reset_n,
  input  logic [MXCLSTBITS-1:0] cluster0,
  input  logic [MXCLSTBITS-1:0] cluster1,
  input  logic [MXCLSTBITS-1:0] cluster2,
  input  logic [MXCLSTBITS-1:0] cluster3,
  input  logic [MXCLSTBITS-1:0] cluster4,
  input  logic [MXCLSTBITS-1:0] cluster5,
  input  logic [MXCLSTBITS-1:0] cluster6,
  input  logic [MXCLSTBITS-1:0] cluster7,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MXPADS-1:0]     sbits,
  output logic [3:0]            n_clusters,
  output logic                  overlap_err,
  output logic                  order_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t state_q, state_d;

  logic [1:0]                             idx_q, idx_d;
  logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0]  words_q, words_d;
  logic [MXPADS-1:0]                      acc_q, acc_d;
  logic [3:0]                             cnt_q, cnt_d;
  logic                                   ovl_q, ovl_d;
  logic                                   ord_q, ord_d;
  logic                                   gap_q, gap_d;

  logic                  accept;
  logic                  expanding;
  logic [MXCLSTBITS-1:0] word_a, word_b;
  logic [MXPADS-1:0]     mask_a, mask_b;
  logic                  valid_a, valid_b;

  assign word_a = words_q[{idx_q, 1'b0}];
  assign word_b = words_q[{idx_q, 1'b1}];

  cluster_expander u_exp_a (
    .cluster (word_a),
    .mask    (mask_a),
    .valid   (valid_a)
  );

  cluster_expander u_exp_b (
    .cluster (word_b),
    .mask    (mask_b),
    .valid   (valid_b)
  );

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_EXPAND;
      ST_EXPAND: if (idx_q == 2'd3) state_d = ST_HOLD;
      ST_HOLD:   if (out_ready) state_d = in_valid ? ST_EXPAND : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    expanding = 1'b0;
    case (state_q)
      ST_IDLE:   in_ready = global_reset_n;
      ST_EXPAND: expanding = 1'b1;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = global_reset_n & out_ready;
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready;

  // gap tracks "some earlier slot was empty", so a later valid slot flags ordering.
  always_comb begin
    words_d = words_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    ord_d   = ord_q;
    gap_d   = gap_q;
    if (accept) begin
      words_d = {cluster7, cluster6, cluster5, cluster4, cluster3, cluster2, cluster1, cluster0};
      idx_d   = 2'd0;
      acc_d   = '0;
      cnt_d   = 4'd0;
      ovl_d   = 1'b0;
      ord_d   = 1'b0;
      gap_d   = 1'b0;
    end else if (expanding) begin
      idx_d = idx_q + 2'd1;
      acc_d = acc_q | mask_a | mask_b;
      cnt_d = cnt_q + {3'b000, valid_a} + {3'b000, valid_b};
      if (|((mask_a & acc_q) | (mask_b & (acc_q | mask_a)))) ovl_d = 1'b1;
      if ((valid_a & gap_q) | (valid_b & (gap_q | ~valid_a))) ord_d = 1'b1;
      gap_d = gap_q | ~valid_a | ~valid_b;
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      words_q <= '0;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      ovl_q   <= 1'b0;
      ord_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      words_q <= words_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      ord_q   <= ord_d;
      gap_q   <= gap_d;
    end
  end

  assign sbits       = acc_q;
  assign n_clusters  = cnt_q;
  assign overlap_err = ovl_q;
  assign order_err   = ord_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// tb/tb_cluster_unpacker.sv - scoreboard bench for cluster_unpacker against a chamber-map reference model
module tb_cluster_unpacker;

  localparam int PERIOD = 10;

  typedef logic [7:0][13:0] pkt_t;
  typedef struct {
    logic [1535:0] sbits;
    int            n;
    bit            ovl;
    bit            ord;
    time           t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  pkt_t          cur;
  logic          in_valid;
  logic          in_ready;
  logic [1535:0] sbits;
  logic [3:0]    n_clusters;
  logic          overlap_err;
  logic          order_err;
  logic          out_valid;
  logic          out_ready;

  bit   manual_ready;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb_q[$];

  always #(PERIOD/2) clk = ~clk;

  cluster_unpacker dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .cluster0       (cur[0]),
    .cluster1       (cur[1]),
    .cluster2       (cur[2]),
    .cluster3       (cur[3]),
    .cluster4       (cur[4]),
    .cluster5       (cur[5]),
    .cluster6       (cur[6]),
    .cluster7       (cur[7]),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sbits          (sbits),
    .n_clusters     (n_clusters),
    .overlap_err    (overlap_err),
    .order_err      (order_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_map(input string name, input logic [1535:0] act, input logic [1535:0] expv);
    int first;
    nvec++;
    if (act !== expv) begin
      first = -1;
      for (int i = 0; i < 1536; i++) if (first < 0 && act[i] !== expv[i]) first = i;
      nerr++;
      $display("FAIL %s: got %0d bits set, expected %0d bits set, first differing bit %0d is %b",
               name, $countones(act), $countones(expv), first, act[first]);
    end
  endtask

  // Reference: fill an 8x192 chamber picture slot by slot, then re-index it into VFAT order.
  function automatic exp_t model(input pkt_t p);
    exp_t e;
    bit   map [8][192];
    bit   gap;
    int   adr, cnt, row, key;
    e.sbits = '0; e.n = 0; e.ovl = 0; e.ord = 0; e.t = 0;
    gap = 0;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 192; k++) map[r][k] = 0;
    for (int s = 0; s < 8; s++) begin
      adr = int'(p[s][10:0]);
      cnt = int'(p[s][13:11]);
      if (adr >= 1536) begin
        gap = 1;
      end else begin
        e.n++;
        if (gap) e.ord = 1;
        row = adr / 192;
        key = adr % 192;
        for (int k = key; k <= key + cnt && k < 192; k++) begin
          if (map[row][k]) e.ovl = 1;
          map[row][k] = 1;
        end
      end
    end
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 192; k++)
        if (map[r][k]) e.sbits[((k / 64) * 8 + r) * 64 + (k % 64)] = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk(input int n, input bit ovl, input bit ord);
    exp_t e;
    e.sbits = '0; e.n = n; e.ovl = ovl; e.ord = ord; e.t = 0;
    return e;
  endfunction

  function automatic pkt_t empty_pkt();
    pkt_t p;
    p = {8{14'h07FF}};
    return p;
  endfunction

  function automatic pkt_t gen_pkt();
    pkt_t p;
    int   mode, nv, base;
    mode = $urandom_range(0, 2);
    nv   = $urandom_range(0, 8);
    base = $urandom_range(0, 1500);
    for (int s = 0; s < 8; s++) begin
      logic [10:0] adr;
      logic [2:0]  cnt;
      bit          inv;
      cnt = 3'($urandom_range(0, 7));
      inv = (mode == 1) ? ($urandom_range(0, 3) == 0) : (s >= nv);
      if (inv) adr = ($urandom_range(0, 1) != 0) ? 11'h7FE : 11'h7FF;
      else if (mode == 0) adr = 11'($urandom_range(0, 7) * 192 + $urandom_range(180, 191));
      else if (mode == 1) adr = 11'($urandom_range(0, 1535));
      else adr = 11'(base + $urandom_range(0, 20));
      p[s] = {cnt, adr};
    end
    return p;
  endfunction

  // Entered and left just after a rising edge; pushes the expectation on the accept cycle.
  task automatic send(input pkt_t p, input exp_t e);
    int budget;
    budget   = 0;
    cur      = p;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 100);
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", budget);
      in_valid = 1'b0;
      return;
    end
    e.t = $time;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!manual_ready) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin : monitor
    bit            holding, stalled;
    time           first_t;
    logic [1535:0] ps;
    logic [3:0]    pn;
    logic          po, pr;
    exp_t          e;
    holding = 0;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        holding = 0;
        stalled = 0;
      end else begin
        if (!holding) begin
          holding = 1;
          first_t = $time;
        end
        if (stalled) begin
          chk_map("hold_stable_sbits", sbits, ps);
          chk("hold_stable_n", 64'(n_clusters), 64'(pn));
          chk("hold_stable_flags", 64'({overlap_err, order_err}), 64'({po, pr}));
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_output: out_valid=1 with n_clusters=%0d, expected no result", n_clusters);
          end else begin
            e = sb_q.pop_front();
            chk_map("sbits", sbits, e.sbits);
            chk("n_clusters", 64'(n_clusters), 64'(e.n));
            chk("overlap_err", 64'(overlap_err), 64'(e.ovl));
            chk("order_err", 64'(order_err), 64'(e.ord));
            chk("latency", 64'((first_t - e.t) / PERIOD), 64'd5);
          end
          holding = 0;
          stalled = 0;
        end else begin
          chk("hold_in_ready", 64'(in_ready), 64'd0);
          stalled = 1;
          ps = sbits; pn = n_clusters; po = overlap_err; pr = order_err;
        end
      end
    end
  end

  initial begin : stimulus
    pkt_t p;
    exp_t e;
    bit   seen;
    int   budget;

    manual_ready = 1;
    out_ready    = 1'b0;
    in_valid     = 1'b0;
    cur          = empty_pkt();
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_n_clusters", 64'(n_clusters), 64'd0);
    chk("reset_flags", 64'({overlap_err, order_err}), 64'd0);
    chk_map("reset_sbits", sbits, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 manual_ready = 0;

    p = empty_pkt(); p[0] = {3'd0, 11'd0};
    e = mk(1, 0, 0); e.sbits[0] = 1'b1;
    send(p, e);

    p = empty_pkt(); p[0] = {3'd3, 11'd200};
    e = mk(1, 0, 0); for (int b = 72; b <= 75; b++) e.sbits[b] = 1'b1;
    send(p, e);

    p = empty_pkt(); p[0] = {3'd7, 11'd191};
    e = mk(1, 0, 0); e.sbits[1087] = 1'b1;
    send(p, e);

    p = empty_pkt(); p[0] = {3'd2, 11'd10}; p[1] = {3'd0, 11'd12};
    e = mk(2, 1, 0); for (int b = 10; b <= 12; b++) e.sbits[b] = 1'b1;
    send(p, e);

    p = empty_pkt(); p[1] = {3'd0, 11'd5}; p[2] = {3'd1, 11'd64};
    e = mk(2, 0, 1); e.sbits[5] = 1'b1; e.sbits[512] = 1'b1; e.sbits[513] = 1'b1;
    send(p, e);
    drain();

    // Backpressure: stall 10 cycles in HOLD, then release with the next packet waiting.
    @(posedge clk);
    #1;
    manual_ready = 1;
    out_ready    = 1'b0;
    p = gen_pkt();
    send(p, model(p));
    seen   = 0;
    budget = 0;
    while (!seen && budget < 20) begin
      @(negedge clk);
      seen = out_valid;
      budget++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    p = gen_pkt();
    cur      = p;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_stalled_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    e   = model(p);
    e.t = $time;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    manual_ready = 0;
    drain();

    // Reset in the second EXPAND cycle discards the packet.
    @(posedge clk);
    #1;
    p = empty_pkt(); p[0] = {3'd1, 11'd300}; p[3] = {3'd2, 11'd900};
    send(p, model(p));
    @(posedge clk);
    #1 rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    chk_map("midreset_sbits", sbits, '0);
    chk("midreset_n_clusters", 64'(n_clusters), 64'd0);
    chk("midreset_flags", 64'({overlap_err, order_err}), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("postreset_no_output", 64'(seen), 64'd0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      p = gen_pkt();
      send(p, model(p));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
